imem_loader: RTL and testbench

Boot-time program loader that drives the instruction memory's load port (`in_enable`, `in_instruc`, `Addr`) of the pipelined core. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. It writes each word to consecutive word addresses and holds `in_enable` high, which freezes the PC, until a framed image has been loaded and its checksum verified. It sits between the host byte source (UART RX or testbench) and the core top.

---
 rtl/imem_loader_pkg.sv | 19 +
 rtl/byte_word_assembler.sv | 34 +++
 rtl/imem_loader.sv | 129 ++++++++++++
 tb/tb_imem_loader.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and widths for the boot-time instruction memory loader.
package imem_loader_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned ADDR_W = 64;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [2:0] {
    ST_LEN0  = 3'd0,
    ST_LEN1  = 3'd1,
    ST_DATA  = 3'd2,
    ST_WRITE = 3'd3,
    ST_CHECK = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERROR = 3'd6
  } state_t;

endpackage

// File: rtl/byte_word_assembler.sv
// Little-endian 8->32 assembler: collects three bytes, presents the full word
// combinationally alongside the fourth byte so the caller can register it.
module byte_word_assembler
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic [BYTE_W-1:0] data,
  output logic [WORD_W-1:0] word_c,
  output logic              word_valid_c
);

  logic [WORD_W-BYTE_W-1:0] shreg;
  logic [1:0]               idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
      idx   <= '0;
    end else if (clr) begin
      shreg <= '0;
      idx   <= '0;
    end else if (en) begin
      shreg <= {data, shreg[WORD_W-BYTE_W-1:BYTE_W]};
      idx   <= idx + 2'd1;
    end
  end

  assign word_c       = {data, shreg};
  assign word_valid_c = en && (idx == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Frames a byte stream into instruction words, writes them to the IM load
// port and holds the core frozen until the image checksum is verified.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR = 64'd0,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [BYTE_W-1:0] rx_data,
  output logic              rx_ready,
  input  logic              reload,
  output logic              in_enable,
  output logic              instr_we,
  output logic [WORD_W-1:0] in_instruc,
  output logic [ADDR_W-1:0] Addr,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  words_loaded
);

  state_t             state, state_next;
  logic [BYTE_W-1:0]  csum;
  logic [BYTE_W-1:0]  len_lo;
  logic [CNT_W-1:0]   n_words;
  logic [CNT_W-1:0]   len_c;
  logic               take_c;
  logic               clr_c;
  logic               wr_load_c;
  logic               inc_c;
  logic               asm_en_c;
  logic [WORD_W-1:0]  word_c;
  logic               word_valid_c;

  assign take_c   = rx_valid && rx_ready;
  assign asm_en_c = take_c && (state == ST_DATA);
  assign len_c    = {rx_data, len_lo};

  byte_word_assembler u_asm (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (clr_c),
    .en           (asm_en_c),
    .data         (rx_data),
    .word_c       (word_c),
    .word_valid_c (word_valid_c)
  );

  // Next-state and datapath enables.
  always_comb begin
    state_next = state;
    clr_c      = 1'b0;
    wr_load_c  = 1'b0;
    inc_c      = 1'b0;
    case (state)
      ST_LEN0: if (take_c) state_next = ST_LEN1;
      ST_LEN1: begin
        if (take_c) begin
          if (32'(len_c) > MAX_WORDS)  state_next = ST_ERROR;
          else if (len_c == '0)        state_next = ST_CHECK;
          else                         state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (word_valid_c) begin
          wr_load_c  = 1'b1;
          state_next = ST_WRITE;
        end
      end
      ST_WRITE: begin
        inc_c = 1'b1;
        if (CNT_W'(words_loaded + 16'd1) == n_words) state_next = ST_CHECK;
        else                                         state_next = ST_DATA;
      end
      ST_CHECK: begin
        if (take_c) state_next = (rx_data == csum) ? ST_DONE : ST_ERROR;
      end
      ST_DONE, ST_ERROR: begin
        if (reload) begin
          clr_c      = 1'b1;
          state_next = ST_LEN0;
        end
      end
      default: state_next = ST_LEN0;
    endcase
  end

  // State, datapath and outputs registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_LEN0;
      csum         <= '0;
      len_lo       <= '0;
      n_words      <= '0;
      rx_ready     <= 1'b1;
      in_enable    <= 1'b1;
      instr_we     <= 1'b0;
      in_instruc   <= '0;
      Addr         <= BASE_ADDR;
      done         <= 1'b0;
      err          <= 1'b0;
      words_loaded <= '0;
    end else begin
      state <= state_next;
      if (clr_c) begin
        csum         <= '0;
        words_loaded <= '0;
        Addr         <= BASE_ADDR;
      end else begin
        if (take_c && (state inside {ST_LEN0, ST_LEN1, ST_DATA})) csum <= csum ^ rx_data;
        if (inc_c) words_loaded <= CNT_W'(words_loaded + 16'd1);
        if (wr_load_c) begin
          in_instruc <= word_c;
          Addr       <= BASE_ADDR + ADDR_W'({words_loaded, 2'b00});
        end
      end
      if (take_c && state == ST_LEN0) len_lo  <= rx_data;
      if (take_c && state == ST_LEN1) n_words <= len_c;
      rx_ready  <= state_next inside {ST_LEN0, ST_LEN1, ST_DATA, ST_CHECK};
      in_enable <= (state_next != ST_DONE);
      instr_we  <= (state_next == ST_WRITE);
      done      <= (state_next == ST_DONE);
      err       <= (state_next == ST_ERROR);
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued as word bytes
// are driven and retired when the loader pulses instr_we.
module tb_imem_loader;

  typedef logic [7:0] bytes_t[$];
  typedef struct packed {
    logic [63:0] addr;
    logic [31:0] instr;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_ready;
  logic        reload = 1'b0;
  logic        in_enable;
  logic        instr_we;
  logic [31:0] in_instruc;
  logic [63:0] Addr;
  logic        done;
  logic        err;
  logic [15:0] words_loaded;

  int total = 0;
  int bad = 0;
  int writes_seen = 0;
  wr_t sb[$];

  imem_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .reload       (reload),
    .in_enable    (in_enable),
    .instr_we     (instr_we),
    .in_instruc   (in_instruc),
    .Addr         (Addr),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Retire one expected write per instr_we cycle.
  always @(negedge clk) begin
    if (rst_n && instr_we) begin
      wr_t e;
      writes_seen++;
      check("we_no_xfer", 64'(rx_valid && rx_ready), 64'd0);
      if (sb.size() == 0) begin
        check("sb_unexpected_write", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check("wr_addr", Addr, e.addr);
        check("wr_instr", 64'(in_instruc), 64'(e.instr));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit rnd);
    bit ok = 1'b0;
    if (rnd) begin
      int gap = $urandom_range(0, 3);
      repeat (gap) begin
        @(negedge clk);
        rx_valid = 1'b0;
      end
    end
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = b;
      ok = rx_ready;
      @(posedge clk);
    end
    #1 rx_valid = 1'b0;
    if (!ok) check("byte_timeout", 64'd1, 64'd0);
  endtask

  task automatic send_frame(input bytes_t f, input bit rnd);
    int n;
    n = (f.size() >= 2) ? int'({f[1], f[0]}) : 0;
    for (int i = 0; i < f.size(); i++) begin
      if (i >= 5 && ((i - 2) % 4) == 3 && i < 2 + 4 * n) begin
        wr_t e;
        int k = (i - 2) / 4;
        e.addr  = 64'(k * 4);
        e.instr = {f[i], f[i-1], f[i-2], f[i-3]};
        sb.push_back(e);
      end
      send_byte(f[i], rnd);
    end
  endtask

  task automatic pulse_reload();
    @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_rx_ready"}, 64'(rx_ready), 64'd1);
    check({pfx, "_in_enable"}, 64'(in_enable), 64'd1);
    check({pfx, "_instr_we"}, 64'(instr_we), 64'd0);
    check({pfx, "_addr"}, Addr, 64'd0);
    check({pfx, "_done"}, 64'(done), 64'd0);
    check({pfx, "_err"}, 64'(err), 64'd0);
    check({pfx, "_words"}, 64'(words_loaded), 64'd0);
  endtask

  initial begin
    bytes_t good, badchk, empty, toolong, part;
    int w0;
    good    = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00, 8'hC3};
    badchk  = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00, 8'hC4};
    empty   = '{8'h00, 8'h00, 8'h00};
    toolong = '{8'h01, 8'h04};
    part    = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50};

    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    check("rst_instr", 64'(in_instruc), 64'd0);
    rst_n = 1'b1;

    // Good two-word image.
    send_frame(good, 1'b0);
    @(negedge clk);
    check("good_done", 64'(done), 64'd1);
    check("good_err", 64'(err), 64'd0);
    check("good_in_enable", 64'(in_enable), 64'd0);
    check("good_words", 64'(words_loaded), 64'd2);
    check("good_writes", 64'(writes_seen), 64'd2);

    // Bad checksum, then reload.
    pulse_reload();
    send_frame(badchk, 1'b0);
    @(negedge clk);
    check("badchk_err", 64'(err), 64'd1);
    check("badchk_done", 64'(done), 64'd0);
    check("badchk_in_enable", 64'(in_enable), 64'd1);
    check("badchk_words", 64'(words_loaded), 64'd2);
    pulse_reload();
    check("reload_rx_ready", 64'(rx_ready), 64'd1);
    check("reload_err", 64'(err), 64'd0);
    check("reload_words", 64'(words_loaded), 64'd0);
    check("reload_in_enable", 64'(in_enable), 64'd1);

    // Empty image.
    w0 = writes_seen;
    send_frame(empty, 1'b0);
    @(negedge clk);
    check("empty_done", 64'(done), 64'd1);
    check("empty_in_enable", 64'(in_enable), 64'd0);
    check("empty_no_write", 64'(writes_seen - w0), 64'd0);

    // Oversize length.
    pulse_reload();
    w0 = writes_seen;
    send_frame(toolong, 1'b0);
    @(negedge clk);
    check("long_err", 64'(err), 64'd1);
    check("long_rx_ready", 64'(rx_ready), 64'd0);
    check("long_done", 64'(done), 64'd0);
    repeat (4) @(negedge clk);
    check("long_no_write", 64'(writes_seen - w0), 64'd0);

    // Gappy valid on the good image.
    pulse_reload();
    w0 = writes_seen;
    send_frame(good, 1'b1);
    @(negedge clk);
    check("rnd_done", 64'(done), 64'd1);
    check("rnd_words", 64'(words_loaded), 64'd2);
    check("rnd_writes", 64'(writes_seen - w0), 64'd2);

    // Reset mid-load, then full resend.
    pulse_reload();
    send_frame(part, 1'b0);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_vals("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    w0 = writes_seen;
    send_frame(good, 1'b0);
    @(negedge clk);
    check("resend_done", 64'(done), 64'd1);
    check("resend_words", 64'(words_loaded), 64'd2);
    check("resend_writes", 64'(writes_seen - w0), 64'd2);

    repeat (3) @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
